pb_port_hub: RTL

Parametrised PicoBlaze I/O hub: decodes `pb_port_id` into one GPIO port, an interrupt controller and `NCH` UART-style stream channels. It sits between the PicoBlaze CPU and its peripherals, replacing hand-written per-design port decode. Beyond plain decode, it holds the LED/GPIO output register, generates registered read-acknowledge pulses, and latches per-channel RX interrupts with a mask and write-1-to-clear pending register that drive `pb_interrupt`.

---
 rtl/pb_port_hub.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/pb_port_hub.sv
// pb_port_hub: PicoBlaze I/O hub.
// Decodes pb_port_id into a GPIO port, a small interrupt controller and NCH
// stream channels. It holds the LED register, returns read data one cycle
// after the address (registered read mux) and issues a one-cycle RX pop
// pulse after the CPU has captured a channel byte. Per-channel RX interrupts
// are latched on rising edges of rx_present, masked, and cleared by writing
// ones to the pending register.
//
// Port map:
//   0x00         read gpio_in      / write gpio_out
//   0x01         read pending      / write-1-to-clear pending
//   0x02         read mask         / write mask
//   BASE+2i      read rx_data[i]   / write pushes tx byte to channel i
//   BASE+2i+1    read {tx_full[i], rx_present[i]} / writes ignored
// NCH must lie in 1..8, BASE >= 0x03 and BASE + 2*NCH - 1 <= 0xFF so that
// channel addresses never alias the fixed registers or wrap.

module pb_port_hub #(
    parameter int         NCH  = 2,
    parameter logic [7:0] BASE = 8'h10
) (
    input  logic             clk,
    input  logic             pb_reset,
    input  logic [7:0]       pb_port_id,
    input  logic [7:0]       pb_out_port,
    input  logic             pb_write_strobe,
    input  logic             pb_read_strobe,
    output logic [7:0]       pb_in_port,
    output logic             pb_interrupt,
    input  logic [7:0]       gpio_in,
    output logic [7:0]       gpio_out,
    input  logic [8*NCH-1:0] rx_data,
    input  logic [NCH-1:0]   rx_present,
    output logic [NCH-1:0]   rx_ack,
    output logic [7:0]       tx_data,
    output logic [NCH-1:0]   tx_write,
    input  logic [NCH-1:0]   tx_full
);

    localparam logic [7:0] ADDR_GPIO    = 8'h00;
    localparam logic [7:0] ADDR_PENDING = 8'h01;
    localparam logic [7:0] ADDR_MASK    = 8'h02;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic           sel_gpio;
    logic           sel_pending;
    logic           sel_mask;
    logic [NCH-1:0] sel_data;   // BASE+2i : channel data port
    logic [NCH-1:0] sel_stat;   // BASE+2i+1 : channel status port

    assign sel_gpio    = (pb_port_id == ADDR_GPIO);
    assign sel_pending = (pb_port_id == ADDR_PENDING);
    assign sel_mask    = (pb_port_id == ADDR_MASK);

    // One data/status address pair per channel.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chan_decode
            localparam logic [7:0] DATA_ADDR = BASE + 8'(2 * gi);
            localparam logic [7:0] STAT_ADDR = DATA_ADDR + 8'd1;
            assign sel_data[gi] = (pb_port_id == DATA_ADDR);
            assign sel_stat[gi] = (pb_port_id == STAT_ADDR);
        end
    endgenerate

    // TX push is purely combinational and deliberately not gated by tx_full:
    // software is expected to poll the status port before writing.
    assign tx_write = pb_write_strobe ? sel_data : '0;
    assign tx_data  = pb_out_port;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [7:0]     pb_in_port_q,   pb_in_port_d;
    logic           pb_interrupt_q, pb_interrupt_d;
    logic [7:0]     gpio_out_q,     gpio_out_d;
    logic [NCH-1:0] rx_ack_q,       rx_ack_d;
    logic [NCH-1:0] pending_q,      pending_d;
    logic [NCH-1:0] mask_q,         mask_d;
    logic [NCH-1:0] rx_present_q,   rx_present_d;

    logic [7:0]     pending_ext;
    logic [7:0]     mask_ext;
    logic [NCH-1:0] rx_rise;
    logic [NCH-1:0] pending_clr;

    // Zero-extend the NCH-wide registers to the 8-bit read bus.
    always_comb begin
        pending_ext            = '0;
        mask_ext               = '0;
        pending_ext[NCH-1:0]   = pending_q;
        mask_ext[NCH-1:0]      = mask_q;
    end

    // Read mux: evaluated every cycle regardless of the read strobe, so the
    // CPU sees data for the address it presented one cycle earlier.
    always_comb begin
        pb_in_port_d = 8'h00;
        if (sel_gpio) begin
            pb_in_port_d = gpio_in;
        end else if (sel_pending) begin
            pb_in_port_d = pending_ext;
        end else if (sel_mask) begin
            pb_in_port_d = mask_ext;
        end
        for (int i = 0; i < NCH; i++) begin
            if (sel_data[i]) begin
                pb_in_port_d = rx_data[8*i +: 8];
            end
            if (sel_stat[i]) begin
                pb_in_port_d = {6'b000000, tx_full[i], rx_present[i]};
            end
        end
    end

    // RX pop is delayed one cycle so the FIFO advances only after the CPU
    // has sampled the byte on pb_in_port.
    always_comb begin
        rx_ack_d = pb_read_strobe ? sel_data : '0;
    end

    // Software-visible control registers written through the port map.
    always_comb begin
        gpio_out_d = gpio_out_q;
        mask_d     = mask_q;
        if (pb_write_strobe && sel_gpio) begin
            gpio_out_d = pb_out_port;
        end
        if (pb_write_strobe && sel_mask) begin
            mask_d = pb_out_port[NCH-1:0];
        end
    end

    // Interrupt controller: edge-detect rx_present, latch into pending with
    // write-1-to-clear; a new edge in the same cycle as a clear wins.
    always_comb begin
        rx_present_d   = rx_present;
        rx_rise        = rx_present & ~rx_present_q;
        pending_clr    = (pb_write_strobe && sel_pending) ? pb_out_port[NCH-1:0] : '0;
        pending_d      = (pending_q & ~pending_clr) | rx_rise;
        pb_interrupt_d = |(pending_q & mask_q);
    end

    // Read data and RX pop registers.
    always_ff @(posedge clk or posedge pb_reset) begin
        if (pb_reset) begin
            pb_in_port_q <= 8'h00;
            rx_ack_q     <= '0;
        end else begin
            pb_in_port_q <= pb_in_port_d;
            rx_ack_q     <= rx_ack_d;
        end
    end

    // GPIO and mask registers.
    always_ff @(posedge clk or posedge pb_reset) begin
        if (pb_reset) begin
            gpio_out_q <= 8'h00;
            mask_q     <= '0;
        end else begin
            gpio_out_q <= gpio_out_d;
            mask_q     <= mask_d;
        end
    end

    // Interrupt state: edge detector, pending latch and request output.
    always_ff @(posedge clk or posedge pb_reset) begin
        if (pb_reset) begin
            rx_present_q   <= '0;
            pending_q      <= '0;
            pb_interrupt_q <= 1'b0;
        end else begin
            rx_present_q   <= rx_present_d;
            pending_q      <= pending_d;
            pb_interrupt_q <= pb_interrupt_d;
        end
    end

    assign pb_in_port   = pb_in_port_q;
    assign pb_interrupt = pb_interrupt_q;
    assign gpio_out     = gpio_out_q;
    assign rx_ack       = rx_ack_q;

endmodule
